// File: rtl/game_score_ctrl_pkg.sv
// game_score_ctrl_pkg: shared game state and BCD digit types for the score controller
//   game_state_t : IDLE=0, PLAY=1, DEATH=2, OVER=3
//   bcd_digit_t  : one packed BCD digit
package game_score_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DEATH = 2'd2, OVER = 2'd3} game_state_t;
  typedef logic [3:0] bcd_digit_t;
endpackage

// File: rtl/game_score_ctrl_if.sv
// game_score_ctrl_if: event inputs and status outputs of the game/score controller
//   master: vs_in, start, pellet_eat, ghost_hit, blue out; status in
//   slave : frame_tick, ghost_step, respawn, state, lives, game_over, score_bcd out
interface game_score_ctrl_if #(
  parameter int DIGITS     = 6,
  parameter int NUM_GHOSTS = 3,
  parameter int LIVES_W    = 2
);
  import game_score_ctrl_pkg::*;
  logic                  vs_in;
  logic                  start;
  logic                  pellet_eat;
  logic [NUM_GHOSTS-1:0] ghost_hit;
  logic                  blue;
  logic                  frame_tick;
  logic                  ghost_step;
  logic                  respawn;
  game_state_t           state;
  logic [LIVES_W-1:0]    lives;
  logic                  game_over;
  logic [4*DIGITS-1:0]   score_bcd;
  modport master (
    output vs_in, start, pellet_eat, ghost_hit, blue,
    input  frame_tick, ghost_step, respawn, state, lives, game_over, score_bcd
  );
  modport slave (
    input  vs_in, start, pellet_eat, ghost_hit, blue,
    output frame_tick, ghost_step, respawn, state, lives, game_over, score_bcd
  );
endinterface

// File: rtl/game_score_ctrl_bcd_counter.sv
// game_score_ctrl_bcd_counter: DIGITS-wide BCD up-counter that holds at all nines
//   clk, rst_n : clock, async active-low reset
//   inc, clr   : count by one / clear (clear wins)
//   bcd        : packed score, digit 0 in [3:0]
module game_score_ctrl_bcd_counter
  import game_score_ctrl_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  output logic [4*DIGITS-1:0] bcd
);
  bcd_digit_t [DIGITS-1:0] d, d_nx;
  logic carry, full;
  always_comb begin
    carry = inc;
    full  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      full    = full & (d[i] == 4'd9);
      d_nx[i] = carry ? ((d[i] == 4'd9) ? 4'd0 : d[i] + 4'd1) : d[i];
      carry   = carry & (d[i] == 4'd9);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d <= '0;
    else d <= clr ? '0 : full ? d : d_nx;
  assign bcd = d;
endmodule

// File: rtl/game_score_ctrl.sv
// game_score_ctrl: game FSM, lives, ghost-step divider and saturating BCD score
//   Clk, Reset_n : system clock, async active-low reset
//   io (slave)   : vs_in/start/pellet_eat/ghost_hit/blue in;
//                  frame_tick/ghost_step/respawn/state/lives/game_over/score_bcd out
module game_score_ctrl
  import game_score_ctrl_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int NUM_GHOSTS   = 3,
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_W      = 2,
  parameter int PELLET_PTS   = 1,
  parameter int GHOST_PTS    = 5,
  parameter int CHAIN_MAX    = 3,
  parameter int GHOST_DIV    = 2,
  parameter int DEATH_FRAMES = 60,
  parameter int PEND_W       = 10
) (
  input logic             Clk,
  input logic             Reset_n,
  game_score_ctrl_if.slave io
);
  localparam int CHAIN_W = $clog2(CHAIN_MAX + 1);
  localparam int DIV_W   = $clog2(GHOST_DIV + 1);
  localparam int DTH_W   = $clog2(DEATH_FRAMES + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  logic [2:0]         vs_sync;
  logic [CHAIN_W-1:0] chain, chain_nx;
  logic [DIV_W-1:0]   div_cnt;
  logic [DTH_W-1:0]   death_cnt;
  logic [PEND_W-1:0]  pending, pend_nx;
  logic [31:0]        award, pend_sum;
  logic               play, lethal, drain, go;
  assign play   = io.state == PLAY;
  assign lethal = play && |io.ghost_hit && !io.blue;
  assign drain  = pending != '0;
  assign go     = io.start && (io.state == IDLE || io.state == OVER);
  // Ghosts are scored lowest index first, each one doubling the next award.
  always_comb begin
    award    = (play && io.pellet_eat) ? 32'(PELLET_PTS) : 32'd0;
    chain_nx = io.blue ? chain : '0;
    for (int i = 0; i < NUM_GHOSTS; i++)
      if (play && io.blue && io.ghost_hit[i]) begin
        award    = award + (32'(GHOST_PTS) << chain_nx);
        chain_nx = (chain_nx == CHAIN_W'(CHAIN_MAX)) ? chain_nx : chain_nx + CHAIN_W'(1);
      end
    pend_sum = 32'(pending) - 32'(drain) + (lethal ? 32'd0 : award);
    pend_nx  = (pend_sum > 32'(PEND_MAX)) ? PEND_MAX : pend_sum[PEND_W-1:0];
  end
  assign io.ghost_step = play && io.frame_tick && div_cnt == DIV_W'(GHOST_DIV - 1);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      vs_sync       <= '0;
      io.frame_tick <= 1'b0;
      io.respawn    <= 1'b0;
      io.game_over  <= 1'b0;
      io.state      <= IDLE;
      io.lives      <= LIVES_W'(LIVES_INIT);
      chain         <= '0;
      pending       <= '0;
      div_cnt       <= '0;
      death_cnt     <= '0;
    end else begin
      vs_sync       <= {vs_sync[1:0], io.vs_in};
      io.frame_tick <= vs_sync[1] & ~vs_sync[2];
      io.respawn    <= 1'b0;
      chain         <= go ? '0 : chain_nx;
      pending       <= go ? '0 : pend_nx;
      div_cnt       <= !play ? '0 : !io.frame_tick ? div_cnt : io.ghost_step ? '0 : div_cnt + DIV_W'(1);
      death_cnt     <= (io.state != DEATH) ? '0 : death_cnt + DTH_W'(io.frame_tick);
      case (io.state)
        IDLE, OVER:
          if (io.start) begin
            io.state     <= PLAY;
            io.lives     <= LIVES_W'(LIVES_INIT);
            io.game_over <= 1'b0;
          end
        PLAY:
          if (lethal) begin
            io.state     <= (io.lives == LIVES_W'(1)) ? OVER : DEATH;
            io.game_over <= io.lives == LIVES_W'(1);
            io.lives     <= io.lives - LIVES_W'(1);
          end
        DEATH:
          if (io.frame_tick && death_cnt == DTH_W'(DEATH_FRAMES - 1)) begin
            io.state   <= PLAY;
            io.respawn <= 1'b1;
          end
        default: ;
      endcase
    end
  game_score_ctrl_bcd_counter #(.DIGITS(DIGITS)) u_bcd (
    .clk  (Clk),
    .rst_n(Reset_n),
    .inc  (drain),
    .clr  (go),
    .bcd  (io.score_bcd)
  );
endmodule

// File: tb/tb_game_score_ctrl.sv
// tb_game_score_ctrl: directed checks of the game/score controller on two parameter sets
module tb_game_score_ctrl;
  import game_score_ctrl_pkg::*;
  logic Clk = 1'b0, rst_a = 1'b1, rst_b = 1'b1;
  int total = 0, bad = 0, gs_a = 0, ft_a = 0, rs_a = 0, c0 = 0;
  always #5 Clk = ~Clk;
  game_score_ctrl_if #(.DIGITS(6), .NUM_GHOSTS(3), .LIVES_W(2)) ia ();
  game_score_ctrl_if #(.DIGITS(2), .NUM_GHOSTS(3), .LIVES_W(2)) ib ();
  game_score_ctrl dut_a (.Clk(Clk), .Reset_n(rst_a), .io(ia));
  game_score_ctrl #(.DIGITS(2), .LIVES_INIT(1)) dut_b (.Clk(Clk), .Reset_n(rst_b), .io(ib));
  always @(negedge Clk) begin
    if (ia.ghost_step) gs_a++;
    if (ia.frame_tick) ft_a++;
    if (ia.respawn) rs_a++;
  end
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic vs_a(input int n);
    repeat (n) begin
      ia.vs_in = 1'b1;
      step(4);
      ia.vs_in = 1'b0;
      step(4);
    end
  endtask
  initial begin
    ia.vs_in = 0; ia.start = 0; ia.pellet_eat = 0; ia.ghost_hit = '0; ia.blue = 0;
    ib.vs_in = 0; ib.start = 0; ib.pellet_eat = 0; ib.ghost_hit = '0; ib.blue = 0;
    #2 rst_a = 1'b0; rst_b = 1'b0;
    step(2);
    chk("rst_state", ia.state, IDLE);
    chk("rst_lives", ia.lives, 3);
    chk("rst_score", ia.score_bcd, 0);
    chk("rst_pulses", {ia.frame_tick, ia.ghost_step, ia.respawn, ia.game_over}, 0);
    chk("rst_b_lives", ib.lives, 1);
    rst_a = 1'b1; rst_b = 1'b1;
    step(1);
    c0 = gs_a;
    vs_a(4);
    chk("idle_ghost_step", gs_a - c0, 0);
    chk("idle_frame_ticks", ft_a, 4);
    ia.start = 1; step(1); ia.start = 0;
    chk("start_play", ia.state, PLAY);
    ia.pellet_eat = 1; step(7); ia.pellet_eat = 0;
    step(7);
    chk("pellets7", ia.score_bcd, 'h7);
    ia.blue = 1; ia.ghost_hit = 3'b011; step(1);
    ia.ghost_hit = 3'b100; step(1); ia.ghost_hit = '0;
    step(40);
    chk("chain_5_10_20", ia.score_bcd, 'h42);
    ia.ghost_hit = 3'b001; step(1); ia.ghost_hit = '0;
    step(45);
    chk("chain_sat_40", ia.score_bcd, 'h82);
    ia.blue = 0; step(1);
    ia.blue = 1; ia.ghost_hit = 3'b001; step(1); ia.ghost_hit = '0;
    step(10);
    chk("chain_clear_5", ia.score_bcd, 'h87);
    ia.pellet_eat = 1; ia.ghost_hit = 3'b001; step(1);
    ia.pellet_eat = 0; ia.ghost_hit = '0;
    step(15);
    chk("pellet_plus_ghost", ia.score_bcd, 'h98);
    ia.blue = 0; ia.pellet_eat = 1; ia.ghost_hit = 3'b001; step(1);
    ia.pellet_eat = 0; ia.ghost_hit = '0;
    chk("death_state", ia.state, DEATH);
    chk("death_lives", ia.lives, 2);
    ia.pellet_eat = 1; step(3); ia.pellet_eat = 0;
    step(3);
    chk("death_no_score", ia.score_bcd, 'h98);
    c0 = rs_a;
    vs_a(59);
    chk("death_59_state", ia.state, DEATH);
    chk("death_59_respawn", rs_a - c0, 0);
    vs_a(1);
    chk("respawn_state", ia.state, PLAY);
    chk("respawn_pulse", rs_a - c0, 1);
    c0 = gs_a;
    vs_a(10);
    chk("ghost_step_div2", gs_a - c0, 5);
    ib.start = 1; step(1); ib.start = 0;
    ib.blue = 1; ib.ghost_hit = 3'b111; step(1);
    ib.blue = 0; ib.ghost_hit = 3'b001; step(1); ib.ghost_hit = '0;
    chk("over_state", ib.state, OVER);
    chk("over_flag", ib.game_over, 1);
    chk("over_lives", ib.lives, 0);
    chk("over_score0", ib.score_bcd, 'h01);
    step(10);
    chk("over_drain", ib.score_bcd, 'h11);
    step(30);
    chk("over_drained", ib.score_bcd, 'h35);
    ib.start = 1; step(1); ib.start = 0;
    chk("restart_state", ib.state, PLAY);
    chk("restart_score", ib.score_bcd, 0);
    chk("restart_lives", ib.lives, 1);
    chk("restart_flag", ib.game_over, 0);
    ib.pellet_eat = 1; step(95); ib.pellet_eat = 0;
    step(3);
    chk("preload95", ib.score_bcd, 'h95);
    ib.pellet_eat = 1; step(10); ib.pellet_eat = 0;
    step(15);
    chk("sat99", ib.score_bcd, 'h99);
    ib.blue = 1; ib.ghost_hit = 3'b111; step(1);
    ib.blue = 0; ib.ghost_hit = '0;
    step(2);
    chk("sat99_hold", ib.score_bcd, 'h99);
    rst_b = 1'b0;
    #1;
    chk("midrst_state", ib.state, IDLE);
    chk("midrst_score", ib.score_bcd, 0);
    chk("midrst_lives", ib.lives, 1);
    chk("midrst_flags", {ib.game_over, ib.respawn, ib.frame_tick}, 0);
    rst_b = 1'b1;
    step(40);
    chk("post_rst_score", ib.score_bcd, 0);
    chk("post_rst_state", ib.state, IDLE);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
